// File: rtl/ahb_uart_dbg_master.sv
// ahb_uart_dbg_master: UART byte-stream to AHB single-word debug master.
// The host sends 'W' + addr[4] + data[4] or 'R' + addr[4], MSB first. The block
// performs one NONSEQ SINGLE word transfer and replies with 'K', four read bytes,
// or 'E' for any non-OKAY response.
// Optional: define AHB_UART_DBG_TIMEOUT_EN to abandon a partial command after
// TIMEOUT_CYCLES idle cycles and reply 'T'.
module ahb_uart_dbg_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        hbusreq,
   input  logic        hgrant,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [3:0]  hprot,
   output logic        hwrite,
   output logic [31:0] hwdata,
   output logic        hmasterlock,
   input  logic        hready,
   input  logic [31:0] hrdata,
   input  logic [1:0]  hresp,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_REQ, S_APH, S_DPH, S_RESP
   } state_t;

   localparam logic [7:0] CMD_W   = 8'h57;
   localparam logic [7:0] CMD_R   = 8'h52;
   localparam logic [7:0] REP_OK  = 8'h4B;
   localparam logic [7:0] REP_ERR = 8'h45;
   localparam logic [7:0] REP_TO  = 8'h54;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;

   state_t      state, state_nxt;
   logic [7:0]  cmd;
   logic [1:0]  byte_cnt;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] reply_sr;
   logic [2:0]  reply_cnt;
   logic        is_write;
   logic        rx_fire;
   logic        tx_fire;
   logic        timeout_hit;

   assign is_write    = (cmd == CMD_W);
   assign rx_fire     = rx_valid && rx_ready;
   assign tx_fire     = tx_valid && tx_ready;

   // Address low bits are forced to zero: only word transfers are issued.
   assign haddr       = {addr[31:2], 2'b00};
   assign hwdata      = wdata;
   assign hsize       = 3'b010;
   assign hburst      = 3'b000;
   assign hprot       = HPROT_VAL;
   assign hmasterlock = 1'b0;

`ifdef AHB_UART_DBG_TIMEOUT_EN
   logic [31:0] to_cnt;

   // Inter-byte idle counter: runs only while collecting command bytes.
   always_ff @(posedge clk) begin
      if (rst)
         to_cnt <= '0;
      else if ((state == S_ADDR || state == S_DATA) && !rx_fire && !timeout_hit)
         to_cnt <= to_cnt + 32'd1;
      else
         to_cnt <= '0;
   end

   assign timeout_hit = (state == S_ADDR || state == S_DATA) &&
                        (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   logic timeout_unused;
   assign timeout_hit    = 1'b0;
   assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         S_IDLE: if (rx_fire && (rx_data == CMD_W || rx_data == CMD_R)) state_nxt = S_ADDR;
         S_ADDR: begin
            if (timeout_hit)                    state_nxt = S_RESP;
            else if (rx_fire && byte_cnt == 2'd3) state_nxt = is_write ? S_DATA : S_REQ;
         end
         S_DATA: begin
            if (timeout_hit)                    state_nxt = S_RESP;
            else if (rx_fire && byte_cnt == 2'd3) state_nxt = S_REQ;
         end
         S_REQ:  if (hgrant && hready) state_nxt = S_APH;
         S_APH: begin
            if (hready)       state_nxt = S_DPH;
            else if (!hgrant) state_nxt = S_REQ;
         end
         S_DPH:  if (hready) state_nxt = S_RESP;
         S_RESP: if (tx_fire && reply_cnt == 3'd1) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode; rx_ready is also held low while reset is asserted.
   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      hbusreq  = 1'b0;
      htrans   = HTRANS_IDLE;
      hwrite   = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE, S_ADDR, S_DATA: rx_ready = !rst && !timeout_hit;
         S_REQ:  hbusreq = 1'b1;
         S_APH: begin
            // Losing the grant while the bus is stalled withdraws the request.
            htrans = (hgrant || hready) ? HTRANS_NONSEQ : HTRANS_IDLE;
            hwrite = is_write;
         end
         S_RESP: begin
            tx_valid = 1'b1;
            tx_data  = reply_sr[31:24];
         end
         default: ;
      endcase
   end

   // Command capture, AHB response capture and reply shifting.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd       <= '0;
         byte_cnt  <= '0;
         addr      <= '0;
         wdata     <= '0;
         reply_sr  <= '0;
         reply_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (rx_fire) begin
               cmd      <= rx_data;
               byte_cnt <= '0;
            end
            S_ADDR, S_DATA: begin
               if (timeout_hit) begin
                  byte_cnt  <= '0;
                  reply_sr  <= {REP_TO, 24'h0};
                  reply_cnt <= 3'd1;
               end else if (rx_fire) begin
                  if (state == S_ADDR) addr  <= {addr[23:0], rx_data};
                  else                 wdata <= {wdata[23:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            // hresp is judged only on the hready=1 cycle; the first ERROR cycle is ignored.
            S_DPH: if (hready) begin
               if (hresp != HRESP_OKAY) begin
                  reply_sr  <= {REP_ERR, 24'h0};
                  reply_cnt <= 3'd1;
               end else if (is_write) begin
                  reply_sr  <= {REP_OK, 24'h0};
                  reply_cnt <= 3'd1;
               end else begin
                  reply_sr  <= hrdata;
                  reply_cnt <= 3'd4;
               end
            end
            S_RESP: if (tx_fire) begin
               reply_sr  <= {reply_sr[23:0], 8'h00};
               reply_cnt <= reply_cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_uart_dbg_master.sv
// Self-checking bench for ahb_uart_dbg_master: directed vector table, hand-written
// arbitration / stall / reset sequences, and a randomized run against a
// command-level reference model with an AHB slave, arbiter, host and UART sink.
module tb_ahb_uart_dbg_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        hbusreq;
   logic        hgrant = 1'b0;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hmasterlock;
   logic        hready = 1'b1;
   logic [31:0] hrdata = '0;
   logic [1:0]  hresp = '0;
   logic        busy;

   ahb_uart_dbg_master #(.TIMEOUT_CYCLES(100), .HPROT_VAL(4'b0011)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
      .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite),
      .hwdata(hwdata), .hmasterlock(hmasterlock), .hready(hready),
      .hrdata(hrdata), .hresp(hresp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      string       name;
      int          nb;
      logic [71:0] bytes;
      int          ws;
      bit          xf;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      int          ntx;
      logic [31:0] tx;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] host_q[$];
   logic [7:0] tx_got[$];
   logic [7:0] exp_tx[$];
   xfer_t      x_got[$];
   xfer_t      exp_x[$];

   // environment knobs
   int tx_mode    = 0;   // 0 always ready, 1 toggle, 2 random
   int grant_mode = 0;   // 0 granted, 1 withheld, 2 random
   int rx_gap     = 0;   // percent of cycles the host withholds a byte
   int idle_busy  = 0;   // percent of idle cycles another master stalls hready
   int ws_lo      = 0;
   int ws_hi      = 0;

   // slave data-phase state
   bit          dp_active = 0;
   bit          dp_write  = 0;
   bit          dp_err    = 0;
   int          dp_cnt    = 0;
   logic [31:0] dp_addr   = '0;

   bit         stall_prev = 0;
   logic [7:0] stall_data = '0;
   int         hold_viol  = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave memory image: word at 0x10 is fixed, others are a hash of the address.
   function automatic logic [31:0] rd_val(logic [31:0] a);
      return (a == 32'h10) ? 32'h1234_5678 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
   endfunction

   // Slave region 0x2xxxxxxx answers with ERROR.
   function automatic bit err_of(logic [31:0] a);
      return a[31:28] == 4'h2;
   endfunction

   function automatic vec_t mk(string n, int nb, logic [71:0] b, int ws, bit xf,
                               logic [31:0] a, bit wr, logic [31:0] wd, int ntx, logic [31:0] tx);
      vec_t v;
      v.name = n; v.nb = nb; v.bytes = b; v.ws = ws; v.xf = xf; v.addr = a;
      v.wr = wr; v.wdata = wd; v.ntx = ntx; v.tx = tx;
      return v;
   endfunction

   // One clock: drive environment #1 after the edge, observe #2 after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      rx_valid = (host_q.size() > 0) && ($urandom_range(99, 0) >= rx_gap);
      rx_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
      case (tx_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = !tx_ready;
         default: tx_ready = 1'($urandom_range(1, 0));
      endcase
      case (grant_mode)
         0:       hgrant = 1'b1;
         1:       hgrant = 1'b0;
         default: hgrant = ($urandom_range(3, 0) != 0);
      endcase
      if (dp_active) begin
         hready = (dp_cnt == 0);
         hresp  = (dp_err && dp_cnt <= 1) ? 2'b01 : 2'b00;
         hrdata = dp_write ? $urandom : rd_val(dp_addr);
      end else begin
         hready = ($urandom_range(99, 0) >= idle_busy);
         hresp  = 2'b00;
         hrdata = $urandom;
      end
      #1;
      if (stall_prev && !(tx_valid === 1'b1 && tx_data === stall_data)) hold_viol++;
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (rx_valid && rx_ready) void'(host_q.pop_front());
      if (tx_valid && tx_ready) tx_got.push_back(tx_data);
      if (dp_active) begin
         if (hready) begin
            if (dp_write) x_got[x_got.size() - 1].wdata = hwdata;
            dp_active = 0;
         end else begin
            dp_cnt--;
         end
      end
      if (htrans == 2'b10 && hready) begin
         x_got.push_back('{haddr, hwrite, 32'h0});
         dp_active = 1;
         dp_write  = hwrite;
         dp_addr   = haddr;
         dp_err    = err_of(haddr);
         dp_cnt    = $urandom_range(ws_hi, ws_lo) + (dp_err ? 1 : 0);
      end
   endtask

   task automatic run_until_idle(string tag, int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 3 && n < budget) begin
         step();
         n++;
         if (host_q.size() == 0 && !busy && !dp_active) quiet++;
         else quiet = 0;
      end
      check({tag, "_drain"}, 64'(quiet >= 3), 64'd1);
   endtask

   task automatic clear_logs();
      tx_got.delete(); x_got.delete(); exp_tx.delete(); exp_x.delete();
   endtask

   task automatic check_results(string tag);
      check({tag, "_tx_count"}, 64'(tx_got.size()), 64'(exp_tx.size()));
      for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++)
         check($sformatf("%s_tx%0d", tag, i), 64'(tx_got[i]), 64'(exp_tx[i]));
      check({tag, "_xfer_count"}, 64'(x_got.size()), 64'(exp_x.size()));
      for (int i = 0; i < x_got.size() && i < exp_x.size(); i++) begin
         check($sformatf("%s_haddr%0d", tag, i), 64'(x_got[i].addr), 64'(exp_x[i].addr));
         check($sformatf("%s_hwrite%0d", tag, i), 64'(x_got[i].wr), 64'(exp_x[i].wr));
         if (exp_x[i].wr)
            check($sformatf("%s_hwdata%0d", tag, i), 64'(x_got[i].wdata), 64'(exp_x[i].wdata));
      end
   endtask

   // Reference model: expected bus transfer and reply for one host command.
   task automatic model_cmd(logic [7:0] c, logic [31:0] a, logic [31:0] d);
      logic [31:0] aw;
      logic [31:0] rv;
      aw = {a[31:2], 2'b00};
      if (c == 8'h57) begin
         exp_x.push_back('{aw, 1'b1, d});
         exp_tx.push_back(err_of(aw) ? 8'h45 : 8'h4B);
      end else if (c == 8'h52) begin
         exp_x.push_back('{aw, 1'b0, 32'h0});
         if (err_of(aw)) exp_tx.push_back(8'h45);
         else begin
            rv = rd_val(aw);
            for (int k = 3; k >= 0; k--) exp_tx.push_back(rv[k*8 +: 8]);
         end
      end
   endtask

   task automatic push_word(logic [31:0] w);
      for (int k = 3; k >= 0; k--) host_q.push_back(w[k*8 +: 8]);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ctrl"}, 64'({rx_ready, tx_valid, tx_data, hbusreq, htrans, hwrite, busy}), 64'd0);
      check({tag, "_haddr"}, 64'(haddr), 64'd0);
      check({tag, "_hwdata"}, 64'(hwdata), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   n;

      // ---------------- reset state ----------------
      rst = 1'b1;
      step(); step();
      check_reset_outputs("reset");
      check("const_ahb", 64'({hsize, hburst, hprot, hmasterlock}), 64'({3'b010, 3'b000, 4'b0011, 1'b0}));
      rst = 1'b0;
      step();
      check("idle_rx_ready", 64'({rx_ready, busy}), 64'({1'b1, 1'b0}));

      // ---------------- directed vector table ----------------
      vecs[0] = mk("write_ok",    9, 72'h57_00000010_DEADBEEF, 0, 1, 32'h0000_0010, 1, 32'hDEAD_BEEF, 1, 32'h4B);
      vecs[1] = mk("read_ws2",    5, 72'h52_00000010,          2, 1, 32'h0000_0010, 0, 32'h0,        4, 32'h1234_5678);
      vecs[2] = mk("read_error",  5, 72'h52_20000003,          0, 1, 32'h2000_0000, 0, 32'h0,        1, 32'h45);
      vecs[3] = mk("junk",        1, 72'h41,                   0, 0, 32'h0,         0, 32'h0,        0, 32'h0);
      vecs[4] = mk("write_error", 9, 72'h57_20000104_CAFEF00D, 1, 1, 32'h2000_0104, 1, 32'hCAFE_F00D, 1, 32'h45);
      vecs[5] = mk("read_unalign",5, 72'h52_00000ABE,          3, 1, 32'h0000_0ABC, 0, 32'h0,        4, rd_val(32'h0000_0ABC));
      vecs[6] = mk("write_after", 9, 72'h57_4000000C_01020304, 0, 1, 32'h4000_000C, 1, 32'h0102_0304, 1, 32'h4B);

      for (int v = 0; v < 7; v++) begin
         clear_logs();
         ws_lo = vecs[v].ws; ws_hi = vecs[v].ws;
         for (int k = vecs[v].nb - 1; k >= 0; k--) host_q.push_back(vecs[v].bytes[k*8 +: 8]);
         if (vecs[v].xf) exp_x.push_back('{vecs[v].addr, vecs[v].wr, vecs[v].wdata});
         for (int k = vecs[v].ntx - 1; k >= 0; k--) exp_tx.push_back(vecs[v].tx[k*8 +: 8]);
         run_until_idle(vecs[v].name, 200);
         check_results(vecs[v].name);
      end

      // ---------------- arbitration: grant withheld 20 cycles ----------------
      clear_logs();
      ws_lo = 0; ws_hi = 0;
      grant_mode = 1;
      host_q.push_back(8'h52); push_word(32'h0000_0040);
      n = 0;
      while (host_q.size() > 0 && n < 50) begin step(); n++; end
      check("arb_bytes_taken", 64'(host_q.size()), 64'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         check($sformatf("arb_wait%0d", i), 64'({hbusreq, htrans, rx_ready}), 64'({1'b1, 2'b00, 1'b0}));
      end
      grant_mode = 0;
      step();
      check("arb_grant_cycle", 64'({hbusreq, htrans}), 64'({1'b1, 2'b00}));
      step();
      check("arb_aph", 64'({hbusreq, htrans, hwrite}), 64'({1'b0, 2'b10, 1'b0}));
      check("arb_aph_haddr", 64'(haddr), 64'h40);
      model_cmd(8'h52, 32'h0000_0040, 32'h0);
      run_until_idle("arb", 200);
      check_results("arb");

      // ---------------- tx_ready toggling every other cycle ----------------
      clear_logs();
      tx_mode = 1; ws_lo = 2; ws_hi = 2;
      host_q.push_back(8'h52); push_word(32'h0000_0010);
      model_cmd(8'h52, 32'h0000_0010, 32'h0);
      run_until_idle("toggle", 200);
      check_results("toggle");
      tx_mode = 0;

      // ---------------- reset during data phase ----------------
      clear_logs();
      ws_lo = 6; ws_hi = 6;
      host_q.push_back(8'h57); push_word(32'h0000_0080); push_word(32'h1122_3344);
      n = 0;
      while (!dp_active && n < 60) begin step(); n++; end
      check("rst_reach_dph", 64'(dp_active), 64'd1);
      step();
      rst = 1'b1;
      step();
      check_reset_outputs("rst_dph");
      rst = 1'b0;
      dp_active = 0; stall_prev = 0;
      clear_logs();
      ws_lo = 0; ws_hi = 0;
      host_q.push_back(8'h52); push_word(32'h0000_0010);
      model_cmd(8'h52, 32'h0000_0010, 32'h0);
      run_until_idle("after_rst", 200);
      check_results("after_rst");

`ifdef AHB_UART_DBG_TIMEOUT_EN
      // ---------------- inter-byte timeout ----------------
      clear_logs();
      host_q.push_back(8'h57); host_q.push_back(8'h00);
      n = 0;
      while (host_q.size() > 0 && n < 20) begin step(); n++; end
      n = 0;
      while (!tx_valid && n < 300) begin step(); n++; end
      check("timeout_latency", 64'(n), 64'd101);
      exp_tx.push_back(8'h54);
      run_until_idle("timeout", 50);
      check_results("timeout");
`endif

      // ---------------- randomized traffic ----------------
      clear_logs();
      rx_gap = 30; tx_mode = 2; grant_mode = 2; idle_busy = 20; ws_lo = 0; ws_hi = 3;
      for (int i = 0; i < 40; i++) begin
         int          kind;
         logic [7:0]  c;
         logic [31:0] a;
         logic [31:0] d;
         int          nib;
         kind = $urandom_range(9, 0);
         nib  = $urandom_range(3, 0);
         a    = {((nib == 3) ? 4'h4 : 4'(nib)), 28'($urandom)};
         d    = $urandom;
         if (kind < 4)      c = 8'h57;
         else if (kind < 8) c = 8'h52;
         else begin
            c = 8'($urandom);
            while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
         end
         host_q.push_back(c);
         if (c == 8'h57 || c == 8'h52) push_word(a);
         if (c == 8'h57) push_word(d);
         model_cmd(c, a, d);
      end
      run_until_idle("random", 20000);
      check_results("random");

      check("tx_hold_stable", 64'(hold_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_uart_dbg_master.md
Name: ahb_uart_dbg_master

Overview:
- Byte-stream-to-AHB debug master. Occupies the unused M1 master slot of the 2-master AHB matrix.
- Upstream: a UART receiver's byte stream. Downstream: a UART transmitter's byte stream.
- Host issues single-word read/write commands; the block arbitrates for the bus, performs one NONSEQ SINGLE word transfer, and returns a status/data reply.
- Lets a PC load the RAM and poke PIO/APB registers while the CPU runs or is held.

Parameters:
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles (used only with the optional feature).
- HPROT_VAL, 4'b0011: constant value driven on hprot.

Ports:
- clk  in  1  system clock; AHB HCLK domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  command byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts rx_data this cycle.
- tx_data  out  8  reply byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data.
- hbusreq  out  1  AHB bus request.
- hgrant  in  1  AHB grant.
- haddr  out  32  AHB address; bits [1:0] always 0.
- htrans  out  2  AHB transfer type, IDLE (00) or NONSEQ (10).
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- hwrite  out  1  AHB write.
- hwdata  out  32  AHB write data.
- hmasterlock  out  1  constant 0.
- hready  in  1  AHB ready.
- hrdata  in  32  AHB read data.
- hresp  in  2  AHB response.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Protocol: 'W' (0x57) + 4 address bytes + 4 data bytes, all MSB first; 'R' (0x52) + 4 address bytes.
- Replies:
  - write OK: 0x4B ('K').
  - read OK: 4 data bytes, MSB first.
  - any non-OKAY hresp (ERROR, RETRY or SPLIT): single byte 0x45 ('E'). No retry is attempted.
- Any other command byte is consumed and discarded silently; state stays IDLE.
- Reset state is IDLE. Output reset values: rx_ready=0, tx_valid=0, tx_data=0, hbusreq=0, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, busy=0. Byte counters and shift registers are cleared.
- States:
  - IDLE: rx_ready=1. On rx_valid, latch command; go to ADDR if 'R'/'W', else stay in IDLE.
  - ADDR: rx_ready=1. Shift 4 bytes into the address register. After the 4th byte, go to DATA if 'W', else to REQ.
  - DATA: rx_ready=1. Shift 4 bytes into the write-data register, then go to REQ.
  - REQ: rx_ready=0, hbusreq=1, htrans=IDLE. When hgrant && hready, go to APH.
  - APH: drive htrans=NONSEQ, haddr={addr[31:2],2'b00}, hwrite. Hold until hready is sampled high, then go to DPH.
    - hbusreq deasserts in the APH cycle.
    - If hgrant drops while still in APH with hready=0, drive htrans=IDLE and return to REQ.
  - DPH: htrans=IDLE. For writes, hwdata holds the write word. Wait for hready=1.
    - Sample hresp at the hready=1 cycle.
    - An ERROR response's first cycle (hready=0) is ignored; the final decision uses the hready=1 cycle.
    - Capture hrdata on reads. Go to RESP.
  - RESP: present reply bytes one at a time. tx_data is held stable while tx_valid && !tx_ready. Advance on tx_valid && tx_ready. After the last byte, return to IDLE.
- Handshakes: a transfer occurs only on valid && ready in the same cycle. rx_ready is low in REQ/APH/DPH/RESP, so extra host bytes backpressure into the UART RX FIFO.
- Exactly one AHB transfer per command. No byte is dropped or duplicated under arbitrary tx_ready/rx_valid stalls.
- rst asserted mid-operation returns the block to IDLE in the next cycle. If reset lands during APH/DPH, the bus sees htrans=IDLE from the following cycle; the partial command is lost.
- busy = (state != IDLE).

Optional Feature:
- Macro: AHB_UART_DBG_TIMEOUT_EN.
- When defined:
  - A counter runs in ADDR/DATA, resets on every accepted rx byte, and is cleared in all other states.
  - When it reaches TIMEOUT_CYCLES-1, the partial command is discarded, 0x54 ('T') is sent via RESP, and the block returns to IDLE.
- When undefined: no counter; the block waits indefinitely for bytes.

Test Plan:
- Write: rx 57 00 00 00 10 DE AD BE EF with hgrant=1, slave OKAY, zero wait → one NONSEQ, haddr=0x00000010, hwrite=1, hwdata=0xDEADBEEF in the following cycle; tx 0x4B.
- Read: rx 52 00 00 00 10, slave returns 0x12345678 after 2 wait states → tx 12 34 56 78 in order. With tx_ready toggling every other cycle, bytes are unchanged and not duplicated.
- Error: read of 0x20000003 answered with a 2-cycle ERROR → haddr=0x20000000; tx single 0x45; next command is accepted normally.
- Arbitration: hgrant held low 20 cycles after the last address byte → hbusreq=1, htrans=IDLE throughout; transfer starts in the cycle after hgrant && hready; rx_ready=0 during the wait.
- Junk/reset: rx 0x41 → no bus activity and no tx. rst pulsed during DPH → all outputs at reset values the next cycle; a following 'R' command completes correctly.
- Timeout (AHB_UART_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=100): rx 57 00 then silence → tx 0x54 after 100 cycles; no AHB transfer; state IDLE.
